libnet_ack_gen_512: RTL and testbench



---
 rtl/libnet_ack_gen_512.sv | 205 ++++++++++++++++++++
 tb/tb_libnet_ack_gen_512.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/libnet_ack_gen_512.sv
`default_nettype none
// ============================================================================
// Module   : libnet_ack_gen_512
// Brief    : Coalesces rx expected-sequence updates into single-beat 512-bit
//            ACK frames on an AXI-S master; flushes on count or timeout.
//            Optional statistics counters: define LIBNET_ACK_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module libnet_ack_gen_512 #(
    parameter int unsigned  ACK_COALESCE = 4,
    parameter int unsigned  ACK_TIMEOUT  = 256,
    parameter int unsigned  SEQ_LSB      = 344,
    parameter int unsigned  ACK_FLAG     = 376,
    parameter int unsigned  SYN_FLAG     = 377,
    parameter logic [511:0] HDR_TEMPLATE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  seq_expected,
    input  logic         seq_valid,
    output logic [511:0] tx_tdata,
    output logic [63:0]  tx_tkeep,
    output logic         tx_tvalid,
    output logic [63:0]  tx_tuser,
    output logic         tx_tlast,
    input  logic         tx_tready,
    output logic         ack_pending
`ifdef LIBNET_ACK_STATS_EN
    ,
    output logic [31:0]  ack_sent_cnt,
    output logic [31:0]  seq_merged_cnt
`endif
);

    localparam logic [7:0]  c_COALESCE   = 8'(ACK_COALESCE);
    localparam logic [15:0] c_TIMEOUT_M1 = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_seq_latest;
    logic [7:0]    r_pend_cnt, w_pend_nxt;
    logic [15:0]   r_timer, w_timer_nxt;
    logic          r_ack_pending, w_pending_nxt;
    logic          r_tx_tvalid, w_tvalid_nxt;
    logic [511:0]  r_tx_tdata;
    logic [63:0]   r_tx_tkeep;
    logic [63:0]   r_tx_tuser;
    logic          r_tx_tlast;

    logic          w_handshake;
    logic          w_enter_send;
    logic          w_timer_done;
    logic [7:0]    w_pend_inc;
    logic [7:0]    w_pend_upd;
    logic [31:0]   w_seq_upd;
    logic [511:0]  w_frame;

    assign w_handshake  = r_tx_tvalid & tx_tready;
    assign w_pend_inc   = (r_pend_cnt == 8'hFF) ? r_pend_cnt : r_pend_cnt + 8'd1;
    assign w_pend_upd   = seq_valid ? w_pend_inc : r_pend_cnt;
    assign w_seq_upd    = seq_valid ? seq_expected : r_seq_latest;
    assign w_timer_done = r_ack_pending && (r_timer == c_TIMEOUT_M1);

    always_comb begin
        w_frame                  = HDR_TEMPLATE;
        w_frame[SEQ_LSB +: 32]   = w_seq_upd;
        w_frame[ACK_FLAG]        = 1'b1;
        w_frame[SYN_FLAG]        = 1'b0;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend_cnt;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_ack_pending;
        w_tvalid_nxt  = r_tx_tvalid;
        w_enter_send  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (seq_valid) begin
                    w_pend_nxt    = 8'd1;
                    w_timer_nxt   = 16'd0;
                    w_pending_nxt = 1'b1;
                    if (ACK_COALESCE == 1) begin
                        w_enter_send = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_timer_nxt = r_timer + 16'd1;
                w_pend_nxt  = w_pend_upd;
                if ((w_pend_upd >= c_COALESCE) || (r_timer == c_TIMEOUT_M1)) begin
                    w_enter_send = 1'b1;
                end
            end
            ST_SEND: begin
                if (!r_tx_tvalid) begin
                    // Re-entry one cycle after a handshake: build the next beat now
                    w_enter_send = 1'b1;
                end else begin
                    w_pend_nxt = w_pend_upd;
                    if (seq_valid) begin
                        w_pending_nxt = 1'b1;
                    end
                    // Timer freezes at its terminal value so an expiry survives backpressure
                    if (seq_valid && !r_ack_pending) begin
                        w_timer_nxt = 16'd0;
                    end else if (r_ack_pending && !w_timer_done) begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                    if (w_handshake) begin
                        w_tvalid_nxt = 1'b0;
                        if ((w_pend_upd >= c_COALESCE) || w_timer_done) begin
                            w_state_nxt = ST_SEND;
                        end else if (w_pend_upd != 8'd0) begin
                            w_state_nxt = ST_WAIT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_enter_send) begin
            w_state_nxt   = ST_SEND;
            w_tvalid_nxt  = 1'b1;
            w_pend_nxt    = 8'd0;
            w_timer_nxt   = 16'd0;
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_seq_latest  <= 32'd0;
            r_pend_cnt    <= 8'd0;
            r_timer       <= 16'd0;
            r_ack_pending <= 1'b0;
            r_tx_tvalid   <= 1'b0;
            r_tx_tdata    <= '0;
            r_tx_tkeep    <= '0;
            r_tx_tuser    <= '0;
            r_tx_tlast    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_seq_latest  <= w_seq_upd;
            r_pend_cnt    <= w_pend_nxt;
            r_timer       <= w_timer_nxt;
            r_ack_pending <= w_pending_nxt;
            r_tx_tvalid   <= w_tvalid_nxt;
            if (w_enter_send) begin
                r_tx_tdata <= w_frame;
                r_tx_tkeep <= '1;
                r_tx_tuser <= '0;
                r_tx_tlast <= 1'b1;
            end
        end
    end

    assign tx_tdata    = r_tx_tdata;
    assign tx_tkeep    = r_tx_tkeep;
    assign tx_tvalid   = r_tx_tvalid;
    assign tx_tuser    = r_tx_tuser;
    assign tx_tlast    = r_tx_tlast;
    assign ack_pending = r_ack_pending;

`ifdef LIBNET_ACK_STATS_EN
    logic [31:0] r_ack_sent_cnt;
    logic [31:0] r_seq_merged_cnt;

    // An update is merged when a window was already open in the previous cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_sent_cnt   <= 32'd0;
            r_seq_merged_cnt <= 32'd0;
        end else begin
            if (w_handshake) begin
                r_ack_sent_cnt <= r_ack_sent_cnt + 32'd1;
            end
            if (seq_valid && r_ack_pending) begin
                r_seq_merged_cnt <= r_seq_merged_cnt + 32'd1;
            end
        end
    end

    assign ack_sent_cnt   = r_ack_sent_cnt;
    assign seq_merged_cnt = r_seq_merged_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_libnet_ack_gen_512.sv
`default_nettype none
// ============================================================================
// Module   : tb_libnet_ack_gen_512
// Brief    : Scoreboard bench for libnet_ack_gen_512 (coalesce=1 and =4 DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_libnet_ack_gen_512;

    localparam logic [511:0] c_HDR = {16{32'hDEADBEEF}};

    typedef struct {
        logic [31:0] seq;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [31:0]  a_seq, b_seq;
    logic         a_valid, b_valid;
    logic [511:0] a_tdata, b_tdata;
    logic [63:0]  a_tkeep, b_tkeep, a_tuser, b_tuser;
    logic         a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic         a_tready, b_tready, a_pend, b_pend;
`ifdef LIBNET_ACK_STATS_EN
    logic [31:0]  a_acks, a_merged, b_acks, b_merged;
`endif

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    libnet_ack_gen_512 #(.ACK_COALESCE(1)) u_dut_a (
        .clk(clk), .reset(reset), .seq_expected(a_seq), .seq_valid(a_valid),
        .tx_tdata(a_tdata), .tx_tkeep(a_tkeep), .tx_tvalid(a_tvalid),
        .tx_tuser(a_tuser), .tx_tlast(a_tlast), .tx_tready(a_tready),
        .ack_pending(a_pend)
`ifdef LIBNET_ACK_STATS_EN
        , .ack_sent_cnt(a_acks), .seq_merged_cnt(a_merged)
`endif
    );

    libnet_ack_gen_512 #(.ACK_COALESCE(4), .ACK_TIMEOUT(16), .HDR_TEMPLATE(c_HDR)) u_dut_b (
        .clk(clk), .reset(reset), .seq_expected(b_seq), .seq_valid(b_valid),
        .tx_tdata(b_tdata), .tx_tkeep(b_tkeep), .tx_tvalid(b_tvalid),
        .tx_tuser(b_tuser), .tx_tlast(b_tlast), .tx_tready(b_tready),
        .ack_pending(b_pend)
`ifdef LIBNET_ACK_STATS_EN
        , .ack_sent_cnt(b_acks), .seq_merged_cnt(b_merged)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] s, input int c);
        exp_t e;
        e.seq = s;
        e.cyc = c;
        return e;
    endfunction

    function automatic logic [511:0] exp_frame(input logic [31:0] s, input logic [511:0] hdr);
        logic [511:0] f;
        f          = hdr;
        f[375:344] = s;
        f[376]     = 1'b1;
        f[377]     = 1'b0;
        return f;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_b(input logic [31:0] s);
        b_valid = 1'b1;
        b_seq   = s;
        tick();
    endtask

    task automatic wait_empty(input bit use_b, input string name, input int bound);
        int n = 0;
        while (((use_b ? qb.size() : qa.size()) != 0) && n < bound) begin
            tick();
            n++;
        end
        chk(name, 512'(use_b ? qb.size() : qa.size()), 512'd0);
    endtask

    // Monitors: every presented beat is checked against the queue head;
    // the first cycle of a beat is also checked against its expected cycle.
    always @(negedge clk) begin
        if (reset) begin
            a_prev <= 1'b0;
        end else if (a_tvalid) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_beat: got seq %0h, expected no beat", a_tdata[375:344]);
            end else begin
                chk("a_tdata", a_tdata, exp_frame(qa[0].seq, 512'd0));
                chk("a_keep_user_last", 512'({a_tkeep, a_tuser, a_tlast}),
                    512'({64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1}));
                if (!a_prev) chk("a_beat_cycle", 512'(cyc), 512'(qa[0].cyc));
                if (a_tready) qa.delete(0);
            end
            a_prev <= 1'b1;
        end else begin
            a_prev <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            b_prev <= 1'b0;
        end else if (b_tvalid) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_beat: got seq %0h, expected no beat", b_tdata[375:344]);
            end else begin
                chk("b_tdata", b_tdata, exp_frame(qb[0].seq, c_HDR));
                chk("b_keep_user_last", 512'({b_tkeep, b_tuser, b_tlast}),
                    512'({64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1}));
                if (!b_prev) chk("b_beat_cycle", 512'(cyc), 512'(qb[0].cyc));
                if (b_tready) qb.delete(0);
            end
            b_prev <= 1'b1;
        end else begin
            b_prev <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        reset    = 1'b1;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_seq    = 32'd0;
        b_seq    = 32'd0;
        a_tready = 1'b1;
        b_tready = 1'b1;
        repeat (3) tick();

        chk("rst_a_tdata", a_tdata, 512'd0);
        chk("rst_a_ctl", 512'({a_tkeep, a_tuser, a_tvalid, a_tlast, a_pend}), 512'd0);
        chk("rst_b_tdata", b_tdata, 512'd0);
        chk("rst_b_ctl", 512'({b_tkeep, b_tuser, b_tvalid, b_tlast, b_pend}), 512'd0);
        reset = 1'b0;

        // Coalesce=1: update in cycle 5 gives a beat in cycle 6
        while (cyc < 5) tick();
        qa.push_back(mk(32'h10, cyc + 1));
        a_valid = 1'b1;
        a_seq   = 32'h10;
        tick();
        a_valid = 1'b0;
        tick();
        chk("a_idle_after_ack", 512'({a_tvalid, a_pend}), 512'd0);
        qa.push_back(mk(32'hCAFE0001, cyc + 1));
        a_valid = 1'b1;
        a_seq   = 32'hCAFE0001;
        tick();
        a_valid = 1'b0;
        wait_empty(1'b0, "qa_drained_1", 10);

        // Four back-to-back updates -> one ACK carrying 4, the cycle after the 4th
        n0 = cyc;
        qb.push_back(mk(32'd4, n0 + 4));
        for (int i = 1; i <= 4; i++) upd_b(32'(i));
        b_valid = 1'b0;
        wait_empty(1'b1, "qb_drained_burst", 20);
        chk("b_pend_after_burst", 512'(b_pend), 512'd0);

        // Single update: timer decides in cycle N+16, beat registered for N+17
        n0 = cyc;
        qb.push_back(mk(32'h7, n0 + 17));
        upd_b(32'h7);
        b_valid = 1'b0;
        chk("b_pend_after_single", 512'(b_pend), 512'd1);
        while (cyc < n0 + 16) tick();
        chk("b_pend_before_timeout", 512'({b_pend, b_tvalid}), 512'b10);
        tick();
        chk("b_pend_at_timeout", 512'({b_pend, b_tvalid}), 512'b01);
        wait_empty(1'b1, "qb_drained_timeout", 10);

        // Backpressure with updates during SEND; second ACK on timeout
        n0 = cyc;
        qb.push_back(mk(32'h33, n0 + 4));
        qb.push_back(mk(32'h21, n0 + 21));
        b_tready = 1'b0;
        for (int i = 0; i < 4; i++) upd_b(32'h30 + 32'(i));
        upd_b(32'h20);
        upd_b(32'h21);
        b_valid = 1'b0;
        chk("b_held_with_pending", 512'({b_tvalid, b_pend}), 512'b11);
        while (cyc < n0 + 14) tick();
        b_tready = 1'b1;
        wait_empty(1'b1, "qb_drained_backpressure", 30);

        // Sequence moves backward inside one window: latest wins
        n0 = cyc;
        qb.push_back(mk(32'h5, n0 + 17));
        upd_b(32'h100);
        upd_b(32'h5);
        b_valid = 1'b0;
        wait_empty(1'b1, "qb_drained_backward", 30);

        // Timer expires while the first beat is stalled; flush after one idle cycle
        n0 = cyc;
        qb.push_back(mk(32'h43, n0 + 4));
        qb.push_back(mk(32'h44, n0 + 27));
        b_tready = 1'b0;
        for (int i = 0; i < 5; i++) upd_b(32'h40 + 32'(i));
        b_valid = 1'b0;
        while (cyc < n0 + 25) tick();
        b_tready = 1'b1;
        tick();
        chk("b_gap_after_expiry", 512'(b_tvalid), 512'd0);
        wait_empty(1'b1, "qb_drained_expiry", 10);

`ifdef LIBNET_ACK_STATS_EN
        chk("a_stats", 512'({a_acks, a_merged}), 512'({32'd2, 32'd0}));
        chk("b_stats", 512'({b_acks, b_merged}), 512'({32'd7, 32'd11}));
`endif

        // Reset while a beat is stalled and an update is pending
        n0 = cyc;
        qb.push_back(mk(32'h53, n0 + 4));
        b_tready = 1'b0;
        for (int i = 0; i < 5; i++) upd_b(32'h50 + 32'(i));
        b_valid = 1'b0;
        chk("b_stalled_before_reset", 512'({b_tvalid, b_pend}), 512'b11);
        reset = 1'b1;
        tick();
        chk("b_after_reset", 512'({b_tvalid, b_pend}), 512'd0);
`ifdef LIBNET_ACK_STATS_EN
        chk("b_stats_after_reset", 512'({b_acks, b_merged}), 512'd0);
`endif
        qb.delete();
        reset    = 1'b0;
        b_tready = 1'b1;
        repeat (5) tick();
        chk("qa_empty_end", 512'(qa.size()), 512'd0);
        chk("qb_empty_end", 512'(qb.size()), 512'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
